// File: rtl/lcd_refresh_scheduler.sv
// lcd_refresh_scheduler
//
// Schedules character redraws for the clock/date/environment LCD page.
// After the LCD reports it is initialised the whole page is redrawn once;
// from then on only the characters whose source value changed are redrawn.
// Requests go out one at a time, by layout index, to the character renderer.
//
// Ports:
//   sys_clk, sys_rst   clock and synchronous active-high reset
//   init_done          LCD initialised; low holds the scheduler in WAIT_INIT
//   force_full         one-cycle request for a full-page redraw
//   Hour/Minute/Second BCD time fields (8 bits each)
//   Temperature/Humidity binary sensor values (8 bits each)
//   Status             edit/blink status code (4 bits)
//   char_done          renderer finished the current character
//   char_req           one-cycle draw request
//   char_idx           layout index being drawn
//   active_field       job in service (0 idle, 1 full, 2 sec, 3 min, 4 hour, 5 temp, 6 humi)
//   busy               scheduler is in SELECT, ISSUE or WAIT_DONE
//   frame_done         one-cycle pulse when a full redraw completes
//   timeout_err        one-cycle pulse when a character is abandoned
module lcd_refresh_scheduler #(
  parameter int LAST_IDX = 65,
  parameter int TIMEOUT  = 4095
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       init_done,
  input  logic       force_full,
  input  logic [7:0] Hour,
  input  logic [7:0] Minute,
  input  logic [7:0] Second,
  input  logic [7:0] Temperature,
  input  logic [7:0] Humidity,
  input  logic [3:0] Status,
  input  logic       char_done,
  output logic       char_req,
  output logic [6:0] char_idx,
  output logic [2:0] active_field,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout_err
);

  localparam logic [2:0] WAIT_INIT = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] SELECT    = 3'd2;
  localparam logic [2:0] ISSUE     = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;

  localparam logic [2:0] JOB_NONE = 3'd0;
  localparam logic [2:0] JOB_FULL = 3'd1;
  localparam logic [2:0] JOB_SEC  = 3'd2;
  localparam logic [2:0] JOB_MIN  = 3'd3;
  localparam logic [2:0] JOB_HOUR = 3'd4;
  localparam logic [2:0] JOB_TEMP = 3'd5;
  localparam logic [2:0] JOB_HUMI = 3'd6;

  // Dirty bit positions
  localparam int D_S = 0;
  localparam int D_M = 1;
  localparam int D_H = 2;
  localparam int D_T = 3;
  localparam int D_U = 4;

  // The wait counter runs 0..TIMEOUT-1; reaching TIMEOUT-1 on a WAIT_DONE
  // edge means TIMEOUT cycles have been spent waiting.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]    state_reg;
  logic [43:0]   snap_reg;   // {Status, Humidity, Temperature, Hour, Minute, Second}
  logic [43:0]   prev_reg;
  logic [4:0]    dirty_reg;
  logic          full_pending_reg;
  logic [6:0]    end_reg;
  logic [TW-1:0] tmo_cnt_reg;

  logic          chg_status;
  logic [4:0]    dirty_set;
  logic [4:0]    dirty_clr;
  logic [2:0]    sel_job;
  logic [6:0]    sel_start;
  logic          tmo_hit;
  logic          more_work;

  // A status change re-renders every time field (blink/edit highlight).
  assign chg_status     = snap_reg[43:40] != prev_reg[43:40];
  assign dirty_set[D_S] = (snap_reg[7:0]   != prev_reg[7:0])   | chg_status;
  assign dirty_set[D_M] = (snap_reg[15:8]  != prev_reg[15:8])  | chg_status;
  assign dirty_set[D_H] = (snap_reg[23:16] != prev_reg[23:16]) | chg_status;
  assign dirty_set[D_T] =  snap_reg[31:24] != prev_reg[31:24];
  assign dirty_set[D_U] =  snap_reg[39:32] != prev_reg[39:32];

  assign tmo_hit = tmo_cnt_reg == TW'(TIMEOUT - 1);

  // Work that would need servicing once the current job ends; includes
  // requests landing this very cycle so no IDLE bubble is inserted.
  assign more_work = full_pending_reg | force_full | (|dirty_reg) | (|dirty_set);

  // Fixed-priority job pick: full > second > minute > hour > temp > humi.
  always_comb begin
    sel_job   = JOB_NONE;
    sel_start = 7'd0;
    dirty_clr = 5'b0;
    if (full_pending_reg) begin
      sel_job   = JOB_FULL;
      sel_start = 7'd0;
      dirty_clr = 5'b11111;  // full page covers every field
    end else if (dirty_reg[D_S]) begin
      sel_job        = JOB_SEC;
      sel_start      = 7'd26;
      dirty_clr[D_S] = 1'b1;
    end else if (dirty_reg[D_M]) begin
      sel_job        = JOB_MIN;
      sel_start      = 7'd23;
      dirty_clr[D_M] = 1'b1;
    end else if (dirty_reg[D_H]) begin
      sel_job        = JOB_HOUR;
      sel_start      = 7'd20;
      dirty_clr[D_H] = 1'b1;
    end else if (dirty_reg[D_T]) begin
      sel_job        = JOB_TEMP;
      sel_start      = 7'd60;
      dirty_clr[D_T] = 1'b1;
    end else if (dirty_reg[D_U]) begin
      sel_job        = JOB_HUMI;
      sel_start      = 7'd63;
      dirty_clr[D_U] = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg        <= WAIT_INIT;
      snap_reg         <= '0;
      prev_reg         <= '0;
      dirty_reg        <= '0;
      full_pending_reg <= 1'b0;
      end_reg          <= '0;
      tmo_cnt_reg      <= '0;
      char_req         <= 1'b0;
      char_idx         <= '0;
      active_field     <= '0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      // Snapshots keep tracking while idle/uninitialised so re-init never
      // sees a stale difference.
      snap_reg    <= {Status, Humidity, Temperature, Hour, Minute, Second};
      prev_reg    <= snap_reg;
      char_req    <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;

      if (!init_done) begin
        state_reg        <= WAIT_INIT;
        dirty_reg        <= '0;
        full_pending_reg <= 1'b0;
        char_idx         <= '0;
        active_field     <= JOB_NONE;
        busy             <= 1'b0;
        tmo_cnt_reg      <= '0;
      end else begin
        // New changes win over the clear of the job being selected, so a
        // change racing its own selection is redrawn again afterwards.
        if (state_reg == SELECT) begin
          dirty_reg <= (dirty_reg & ~dirty_clr) | dirty_set;
        end else begin
          dirty_reg <= dirty_reg | dirty_set;
        end

        if (state_reg == WAIT_INIT) begin
          full_pending_reg <= 1'b1;
        end else if (state_reg == SELECT && sel_job == JOB_FULL) begin
          full_pending_reg <= force_full;
        end else begin
          full_pending_reg <= full_pending_reg | force_full;
        end

        case (state_reg)
          WAIT_INIT: state_reg <= IDLE;

          IDLE: begin
            if (full_pending_reg || (|dirty_reg)) begin
              state_reg <= SELECT;
              busy      <= 1'b1;
            end
          end

          SELECT: begin
            if (sel_job == JOB_NONE) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              state_reg    <= ISSUE;
              active_field <= sel_job;
              char_idx     <= sel_start;
              end_reg      <= (sel_job == JOB_FULL) ? 7'(LAST_IDX) : sel_start + 7'd1;
            end
          end

          ISSUE: begin
            char_req    <= 1'b1;
            tmo_cnt_reg <= '0;
            state_reg   <= WAIT_DONE;
          end

          WAIT_DONE: begin
            if (char_done || tmo_hit) begin
              timeout_err <= !char_done;
              if (char_idx < end_reg) begin
                char_idx  <= char_idx + 7'd1;
                state_reg <= ISSUE;
              end else begin
                frame_done   <= (active_field == JOB_FULL);
                active_field <= JOB_NONE;
                if (more_work) begin
                  state_reg <= SELECT;
                end else begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
                end
              end
            end else begin
              tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end
          end

          default: begin
            state_reg <= WAIT_INIT;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
